intr_ctrl: RTL and testbench

- Programmable interrupt controller sitting directly upstream of the pipelined exception/interrupt CPU.
- Collects up to N external interrupt sources and drives the CPU's `intr` input.
- Accepts the CPU's `inta` acknowledge, latches the winning source ID, and holds it in service until software writes end-of-interrupt (EOI).
- Exposes a small memory-mapped register file, on the CPU data bus, for mask, pending and vector access.

---
 rtl/intr_ctrl_pkg.sv | 18 +
 rtl/intr_ctrl_prio_enc.sv | 25 ++
 rtl/intr_ctrl.sv | 154 +++++++++++++++
 tb/tb_intr_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map,
// FSM state encoding and the default spurious-interrupt ID.
package intr_ctrl_pkg;

   localparam logic [1:0] A_PEND = 2'd0;
   localparam logic [1:0] A_MASK = 2'd1;
   localparam logic [1:0] A_VEC  = 2'd2;
   localparam logic [1:0] A_EOI  = 2'd3;

   localparam logic [4:0] SPUR_ID_DEFAULT = 5'h1F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } state_e;

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Lowest-index-first priority encoder.
//   req_i   : request vector, bit 0 has highest priority
//   id_o    : index of the winning request (0 when none)
//   valid_o : at least one request is set
module intr_ctrl_prio_enc #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] req_i,
   output logic [4:0]   id_o,
   output logic         valid_o
);

   // Scan from the top down so the lowest set index is written last.
   always_comb begin
      id_o    = '0;
      valid_o = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            id_o    = 5'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// Programmable interrupt controller in front of the CPU.
// Synchronises N irq lines, latches rising edges into PEND, arbitrates
// PEND & MASK by lowest index, raises intr, and holds the acknowledged
// source in service until software writes EOI.
//   clock_i / reset_i : clock, synchronous active-high reset
//   irq_i             : asynchronous interrupt request lines
//   intr_o            : registered interrupt request to the CPU
//   inta_i            : one-cycle acknowledge from the CPU
//   addr_i/we_i/wdata_i/rdata_o : register port (PEND, MASK, VEC, EOI)
//   cur_id_o          : in-service source ID, SPUR_ID when none
//
// state | meaning
// IDLE  | nothing requested; waits for an eligible source
// REQ   | intr asserted; waits for inta
// SERV  | source in service; waits for EOI write
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int unsigned N       = 8,
   parameter logic [4:0]  SPUR_ID = SPUR_ID_DEFAULT
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic [N-1:0] irq_i,
   output logic         intr_o,
   input  logic         inta_i,
   input  logic [1:0]   addr_i,
   input  logic         we_i,
   input  logic [31:0]  wdata_i,
   output logic [31:0]  rdata_o,
   output logic [4:0]   cur_id_o
);

   // Edge detection is held off until the synchronizer has refilled after
   // reset, so a line held high through reset is not seen as a new event.
   localparam logic [1:0] ARM_CYCLES = 2'd3;

   logic [N-1:0] s1_q, s2_q, s3_q;
   logic [1:0]   arm_cnt_q, arm_cnt_d;
   logic [N-1:0] pend_q, pend_d;
   logic [N-1:0] mask_q, mask_d;
   state_e       state_q, state_d;
   logic         intr_q, intr_d;
   logic [4:0]   cur_id_q, cur_id_d;
   logic         in_svc_q, in_svc_d;

   logic [N-1:0] edge_evt, eligible, pend_clr, ack_vec;
   logic [4:0]   win_id;
   logic         win_vld;
   logic         ack;
   logic         eoi_wr;
   logic         unused_wdata;

   assign unused_wdata = ^wdata_i[31:N];

   assign edge_evt = (arm_cnt_q == 2'd0) ? (s2_q & ~s3_q) : '0;
   assign eligible = pend_q & mask_q;
   assign eoi_wr   = we_i && (addr_i == A_EOI);

   intr_ctrl_prio_enc #(.N(N)) u_prio_enc (
      .req_i   (eligible),
      .id_o    (win_id),
      .valid_o (win_vld)
   );

   always_comb begin
      state_d  = state_q;
      cur_id_d = cur_id_q;
      in_svc_d = in_svc_q;
      ack      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_vld) state_d = REQ;
         end
         REQ: begin
            if (inta_i) begin
               if (win_vld) begin
                  cur_id_d = win_id;
                  in_svc_d = 1'b1;
                  ack      = 1'b1;
                  state_d  = SERV;
               end else begin
                  cur_id_d = SPUR_ID;
                  in_svc_d = 1'b0;
                  state_d  = IDLE;
               end
            end else if (!win_vld) begin
               state_d = IDLE;
            end
         end
         SERV: begin
            if (eoi_wr) begin
               cur_id_d = SPUR_ID;
               in_svc_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      intr_d = (state_d == REQ);
   end

   // Arbitration above uses the registered PEND/MASK, so a same-cycle
   // write never changes who gets acknowledged. New events win over clears.
   always_comb begin
      ack_vec  = ack ? (N'(1) << win_id) : '0;
      pend_clr = ack_vec;
      if (we_i && (addr_i == A_PEND)) pend_clr = pend_clr | wdata_i[N-1:0];
      pend_d = (pend_q & ~pend_clr) | edge_evt;
      mask_d = (we_i && (addr_i == A_MASK)) ? wdata_i[N-1:0] : mask_q;
      arm_cnt_d = (arm_cnt_q != 2'd0) ? arm_cnt_q - 2'd1 : 2'd0;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         arm_cnt_q <= ARM_CYCLES;
         pend_q    <= '0;
         mask_q    <= '0;
         state_q   <= IDLE;
         intr_q    <= 1'b0;
         cur_id_q  <= SPUR_ID;
         in_svc_q  <= 1'b0;
      end else begin
         s1_q      <= irq_i;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         arm_cnt_q <= arm_cnt_d;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         state_q   <= state_d;
         intr_q    <= intr_d;
         cur_id_q  <= cur_id_d;
         in_svc_q  <= in_svc_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      unique case (addr_i)
         A_PEND: rdata_o = {{(32 - N){1'b0}}, pend_q};
         A_MASK: rdata_o = {{(32 - N){1'b0}}, mask_q};
         A_VEC:  rdata_o = {in_svc_q, 26'b0, cur_id_q};
         A_EOI:  rdata_o = '0;
         default: rdata_o = '0;
      endcase
   end

   assign intr_o   = intr_q;
   assign cur_id_o = cur_id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

   localparam int N = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] irq;
   logic         intr;
   logic         inta;
   logic [1:0]   addr;
   logic         we;
   logic [31:0]  wdata;
   logic [31:0]  rdata;
   logic [4:0]   cur_id;

   int checks   = 0;
   int failures = 0;

   intr_ctrl #(.N(N), .SPUR_ID(5'h1F)) dut (
      .clock_i  (clock),
      .reset_i  (reset),
      .irq_i    (irq),
      .intr_o   (intr),
      .inta_i   (inta),
      .addr_i   (addr),
      .we_i     (we),
      .wdata_i  (wdata),
      .rdata_o  (rdata),
      .cur_id_o (cur_id)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_intr;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      tick();
      we = 1'b0; wdata = '0;
   endtask

   task automatic pulse_inta();
      inta = 1'b1;
      tick();
      inta = 1'b0;
   endtask

   task automatic pulse_irq(input logic [N-1:0] v);
      irq = v;
      tick();
      irq = '0;
   endtask

   initial begin
      reset = 1'b1; irq = '0; inta = 1'b0; addr = '0; we = 1'b0; wdata = '0;

      vecs[0] = '{1'b0, 2'd1, 32'h0,         32'h0000_0000, 1'b0};
      vecs[1] = '{1'b0, 2'd0, 32'h0,         32'h0000_0000, 1'b0};
      vecs[2] = '{1'b0, 2'd2, 32'h0,         32'h0000_001F, 1'b0};
      vecs[3] = '{1'b0, 2'd3, 32'h0,         32'h0000_0000, 1'b0};
      vecs[4] = '{1'b1, 2'd1, 32'hFFFF_FFA5, 32'h0000_0000, 1'b0};
      vecs[5] = '{1'b0, 2'd1, 32'h0,         32'h0000_00A5, 1'b0};
      vecs[6] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[7] = '{1'b0, 2'd0, 32'h0,         32'h0000_0000, 1'b0};
      vecs[8] = '{1'b1, 2'd1, 32'h0000_0000, 32'h0000_00A5, 1'b0};
      vecs[9] = '{1'b0, 2'd1, 32'h0,         32'h0000_0000, 1'b0};

      tick(); tick();
      reset = 1'b0;

      // Register-file vectors: rdata is checked before the write edge.
      for (int i = 0; i < 10; i++) begin
         we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
         #1;
         check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_intr", i), {31'b0, intr}, {31'b0, vecs[i].exp_intr});
         tick();
      end
      we = 1'b0; wdata = '0;
      check("reset_cur_id", {27'b0, cur_id}, 32'h1F);

      // 1: single source, pipeline latency, EOI ignored in REQ, ack.
      bus_write(2'd1, 32'h04);
      pulse_irq(8'h04);                        // edge k
      tick();                                  // k+1
      chk_reg("s1_pend_k1", 2'd0, 32'h00);
      tick();                                  // k+2
      chk_reg("s1_pend_k2", 2'd0, 32'h04);
      check("s1_intr_k2", {31'b0, intr}, 32'h0);
      tick();                                  // k+3
      check("s1_intr_k3", {31'b0, intr}, 32'h1);
      bus_write(2'd3, 32'h0);
      check("s1_eoi_in_req_intr", {31'b0, intr}, 32'h1);
      check("s1_eoi_in_req_id", {27'b0, cur_id}, 32'h1F);
      pulse_inta();
      check("s1_cur_id", {27'b0, cur_id}, 32'h2);
      chk_reg("s1_pend_ack", 2'd0, 32'h00);
      chk_reg("s1_vec", 2'd2, 32'h8000_0002);
      check("s1_intr_serv", {31'b0, intr}, 32'h0);
      bus_write(2'd3, 32'h0);
      chk_reg("s1_vec_eoi", 2'd2, 32'h0000_001F);

      // 2: priority, no nesting, EOI re-request, W1C together with inta.
      bus_write(2'd1, 32'hFF);
      pulse_irq(8'h22);
      tick(); tick(); tick();
      check("s2_intr", {31'b0, intr}, 32'h1);
      pulse_inta();
      check("s2_cur_id1", {27'b0, cur_id}, 32'h1);
      chk_reg("s2_pend_serv", 2'd0, 32'h20);
      tick(); tick();
      check("s2_intr_serv", {31'b0, intr}, 32'h0);
      bus_write(2'd3, 32'hDEAD_BEEF);
      check("s2_intr_eoi", {31'b0, intr}, 32'h0);
      check("s2_id_eoi", {27'b0, cur_id}, 32'h1F);
      tick();
      check("s2_intr_rereq", {31'b0, intr}, 32'h1);
      we = 1'b1; addr = 2'd0; wdata = 32'h20; inta = 1'b1;
      tick();
      we = 1'b0; wdata = '0; inta = 1'b0;
      check("s2_cur_id5", {27'b0, cur_id}, 32'h5);
      chk_reg("s2_pend_w1c_ack", 2'd0, 32'h00);
      chk_reg("s2_vec5", 2'd2, 32'h8000_0005);
      bus_write(2'd3, 32'h0);

      // 3: masked source still pends; unmask raises intr; level held.
      bus_write(2'd1, 32'h00);
      irq = 8'h08;
      tick(); tick(); tick();
      chk_reg("s3_pend", 2'd0, 32'h08);
      tick(); tick();
      check("s3_intr_masked", {31'b0, intr}, 32'h0);
      bus_write(2'd1, 32'h08);
      check("s3_intr_j", {31'b0, intr}, 32'h0);
      tick();
      check("s3_intr_j1", {31'b0, intr}, 32'h1);

      // 4: MASK write in the same cycle as inta uses the old mask.
      we = 1'b1; addr = 2'd1; wdata = 32'h0; inta = 1'b1;
      tick();
      we = 1'b0; inta = 1'b0;
      check("s4_cur_id", {27'b0, cur_id}, 32'h3);
      chk_reg("s4_vec", 2'd2, 32'h8000_0003);
      chk_reg("s4_mask", 2'd1, 32'h00);
      tick(); tick(); tick();
      chk_reg("s4_level_once", 2'd0, 32'h00);
      irq = '0;
      bus_write(2'd3, 32'h0);

      // 4b: masking while in REQ withdraws intr.
      bus_write(2'd1, 32'hFF);
      pulse_irq(8'h08);
      tick(); tick(); tick();
      check("s4b_intr", {31'b0, intr}, 32'h1);
      bus_write(2'd1, 32'h00);
      tick();
      check("s4b_intr_drop", {31'b0, intr}, 32'h0);
      pulse_inta();
      chk_reg("s4b_vec_idle", 2'd2, 32'h0000_001F);
      chk_reg("s4b_pend", 2'd0, 32'h08);

      // 5: inta after software cleared the only pending source.
      bus_write(2'd1, 32'h08);
      tick();
      check("s5_intr", {31'b0, intr}, 32'h1);
      bus_write(2'd0, 32'h08);
      pulse_inta();
      check("s5_cur_id_spur", {27'b0, cur_id}, 32'h1F);
      chk_reg("s5_vec", 2'd2, 32'h0000_001F);
      check("s5_intr", {31'b0, intr}, 32'h0);
      tick();
      check("s5_idle", {31'b0, intr}, 32'h0);

      // 6: reset in SERV; irq held across reset yields no event.
      bus_write(2'd1, 32'hFF);
      pulse_irq(8'h31);
      tick(); tick(); tick();
      pulse_inta();
      check("s6_cur_id", {27'b0, cur_id}, 32'h0);
      chk_reg("s6_pend", 2'd0, 32'h30);
      irq = 8'h80; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reg("s6_pend_rst", 2'd0, 32'h00);
      chk_reg("s6_mask_rst", 2'd1, 32'h00);
      chk_reg("s6_vec_rst", 2'd2, 32'h0000_001F);
      check("s6_intr_rst", {31'b0, intr}, 32'h0);
      check("s6_id_rst", {27'b0, cur_id}, 32'h1F);
      for (int i = 0; i < 6; i++) tick();
      chk_reg("s6_no_evt", 2'd0, 32'h00);
      irq = '0;
      tick(); tick(); tick();
      pulse_irq(8'h80);
      tick(); tick();
      chk_reg("s6_new_evt", 2'd0, 32'h80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
